// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster timing constants and the coordinate type
// shared by the VGA timing blocks.
package vga_timing_pkg;

    localparam int unsigned H_VISIBLE_DEF = 640;
    localparam int unsigned H_FRONT_DEF   = 16;
    localparam int unsigned H_SYNC_DEF    = 96;
    localparam int unsigned H_BACK_DEF    = 48;
    localparam int unsigned V_VISIBLE_DEF = 480;
    localparam int unsigned V_FRONT_DEF   = 10;
    localparam int unsigned V_SYNC_DEF    = 2;
    localparam int unsigned V_BACK_DEF    = 33;

    localparam int unsigned H_TOTAL = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int unsigned V_TOTAL = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    typedef logic [9:0] coord_t;

endpackage

// File: rtl/vga_wrap_counter.sv
// Enabled up-counter that wraps from MAX to 0; wrap flags the enabled
// cycle on which the counter returns to 0.
module vga_wrap_counter
    import vga_timing_pkg::*;
#(
    parameter coord_t MAX = coord_t'(H_TOTAL - 1)
) (
    input  logic   Clk,
    input  logic   Reset,
    input  logic   en,
    output coord_t count,
    output logic   wrap
);

    assign wrap = en && (count == MAX);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : coord_t'(count + 1'b1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: halves Clk into the pixel rate, runs the h/v
// counters and produces registered sync, blank and line/frame pulses.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
    parameter int unsigned H_FRONT   = H_FRONT_DEF,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BACK    = H_BACK_DEF,
    parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
    parameter int unsigned V_FRONT   = V_FRONT_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_BACK    = V_BACK_DEF
) (
    input  logic   Clk,
    input  logic   Reset,
    output logic   VGA_CLK,
    output coord_t DrawX,
    output coord_t DrawY,
    output logic   VGA_HS,
    output logic   VGA_VS,
    output logic   VGA_BLANK_N,
    output logic   frame_start,
    output logic   line_start
);

    localparam coord_t H_LAST     = coord_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam coord_t V_LAST     = coord_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam coord_t H_VIS_END  = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS_END  = coord_t'(V_VISIBLE);
    localparam coord_t HS_START   = coord_t'(H_VISIBLE + H_FRONT);
    localparam coord_t HS_END     = coord_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam coord_t VS_START   = coord_t'(V_VISIBLE + V_FRONT);
    localparam coord_t VS_END     = coord_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic   ph;
    logic   h_wrap;
    logic   v_wrap;
    coord_t hc;
    coord_t vc;
    coord_t hc_next;
    coord_t vc_next;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ph <= 1'b0;
        end else begin
            ph <= ~ph;
        end
    end

    vga_wrap_counter #(.MAX(H_LAST)) u_h_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .en    (ph),
        .count (hc),
        .wrap  (h_wrap)
    );

    vga_wrap_counter #(.MAX(V_LAST)) u_v_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .en    (ph && h_wrap),
        .count (vc),
        .wrap  (v_wrap)
    );

    // Look-ahead of the counters so the decode registers land on the
    // same edge as the coordinates they describe.
    always_comb begin
        hc_next = hc;
        vc_next = vc;
        if (h_wrap) begin
            hc_next = '0;
        end else if (ph) begin
            hc_next = coord_t'(hc + 1'b1);
        end
        if (v_wrap) begin
            vc_next = '0;
        end else if (h_wrap) begin
            vc_next = coord_t'(vc + 1'b1);
        end
    end

    // ph toggles every cycle, so the next phase is 0 exactly when ph is 1.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b1;
            line_start  <= 1'b1;
            frame_start <= 1'b1;
        end else begin
            VGA_HS      <= !((hc_next >= HS_START) && (hc_next <= HS_END));
            VGA_VS      <= !((vc_next >= VS_START) && (vc_next <= VS_END));
            VGA_BLANK_N <= (hc_next < H_VIS_END) && (vc_next < V_VIS_END);
            line_start  <= ph && (hc_next == '0);
            frame_start <= ph && (hc_next == '0) && (vc_next == '0);
        end
    end

    assign VGA_CLK = ph;
    assign DrawX   = hc;
    assign DrawY   = vc;

endmodule
